// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 8N1 framing with sticky error flags and a one-byte holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and enable the parity_err flag.
module uart_rx (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       sam_clk,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] shift, shift_nxt;
  logic       armed;
  logic       accept;
  logic       frame_fail;
`ifdef UART_RX_PARITY_EN
  logic       parity_fail;
`endif

  // Both inputs cross from other clock domains; the extra sam_clk stage feeds edge detection.
  logic [1:0] rx_sync;
  logic [2:0] sam_sync;
  logic       rx_s;
  logic       sam_tick;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_sync  <= 2'b11;
      sam_sync <= 3'b000;
    end else begin
      rx_sync  <= {rx_sync[0], rx};
      sam_sync <= {sam_sync[1:0], sam_clk};
    end
  end

  assign rx_s     = rx_sync[1];
  assign sam_tick = sam_sync[1] & ~sam_sync[2];
  assign busy     = (state != IDLE);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx   <= 3'd0;
      shift <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shift_nxt  = shift;
    accept     = 1'b0;
    frame_fail = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_fail = 1'b0;
`endif
    if (sam_tick) begin
      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state_nxt = START;
            cnt_nxt   = 4'd0;
          end
        end
        START: begin
          if (cnt == 4'd7) begin
            cnt_nxt = 4'd0;
            if (!rx_s) begin
              state_nxt = DATA;
              idx_nxt   = 3'd0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        DATA: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == 4'd15) begin
            shift_nxt[idx] = rx_s;
            idx_nxt        = idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == 4'd15) begin
            parity_fail = ^{shift, rx_s};
            state_nxt   = STOP;
          end
        end
`endif
        STOP: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == 4'd15) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            if (rx_s) accept = 1'b1;
            else      frame_fail = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A bad stop bit disarms the receiver until the line has been seen idle again.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)                  armed <= 1'b0;
    else if (frame_fail)        armed <= 1'b0;
    else if (sam_tick && rx_s)  armed <= 1'b1;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // An ack in the same cycle frees the holding register for the new byte.
      if (accept && (!rx_valid || rx_ack)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      if (accept && rx_valid && !rx_ack) overrun <= 1'b1;
      else if (rx_ack)                   overrun <= 1'b0;

      if (frame_fail)  frame_err <= 1'b1;
      else if (rx_ack) frame_err <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)            parity_err <= 1'b0;
    else if (parity_fail) parity_err <= 1'b1;
    else if (rx_ack)      parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port: sysclk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: sam_clk  input  1  16x-oversample clock from baud generator, period 650 sysclk cycles, asynchronous to the logic.
REQ-004 SHALL have port: rx  input  1  serial line, idle high, 8N1 (8E1 with parity), LSB first.
REQ-005 SHALL have port: rx_ack  input  1  consumer acknowledge, one-cycle pulse or level.
REQ-006 SHALL have port: rx_data  output  8  last received byte, held until next accepted frame.
REQ-007 SHALL have port: rx_valid  output  1  byte available, held until acknowledged.
REQ-008 SHALL have ports: frame_err, parity_err, overrun  output  1 each  sticky status flags.
REQ-009 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL pass rx and sam_clk each through a 2-flop synchronizer; sam_tick = 1-cycle pulse on synchronized sam_clk rising edge.
REQ-011 SHALL advance the FSM and tick counter (4-bit, wraps 15->0) only in cycles where sam_tick=1.
REQ-012 FSM states: IDLE, START, DATA, PARITY (present only with UART_RX_PARITY_EN), STOP.
REQ-013 IDLE: armed and rx_s=0 on sam_tick -> START, counter=0; armed sets when rx_s=1 seen on any sam_tick.
REQ-014 START: on 8th tick (counter=7) rx_s=0 -> DATA, counter=0, bit index=0; rx_s=1 -> IDLE (glitch reject, no flag).
REQ-015 DATA: on every 16th tick (counter=15) shift rx_s into bit[index], index+1; after index 7 -> PARITY or STOP.
REQ-016 STOP: on counter=15, rx_s=1 -> frame accepted, rx_s=0 -> frame_err=1, byte discarded, armed cleared, -> IDLE either way.
REQ-017 Accept: rx_data and rx_valid=1 update on the sysclk edge after the sam_tick cycle that samples the stop bit.
REQ-018 rx_valid SHALL stay 1 until rx_ack=1 is sampled; rx_ack with rx_valid=0 is ignored.
REQ-019 Accept while rx_valid=1: new byte dropped, rx_data unchanged, overrun=1.
REQ-020 Accept and rx_ack in same cycle: rx_ack clears old byte, new byte loaded, rx_valid stays 1, no overrun.
REQ-021 frame_err, parity_err, overrun SHALL clear only on rx_ack or reset.
REQ-022 Line dropping low mid-frame SHALL NOT restart; frame completes per counter.

Reset
REQ-023 reset SHALL asynchronously force: state=IDLE, counter=0, index=0, shift reg=0, armed=0, rx_data=8'h00, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, synchronizers to 1 (rx) / 0 (sam_clk).
REQ-024 Reset mid-frame SHALL discard the partial byte; no rx_valid from it after release.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: PARITY state samples bit 9 at counter=15; even parity mismatch sets parity_err=1 and byte is still delivered; frame = 11 bits.
REQ-026 Macro UART_RX_PARITY_EN undefined: no PARITY state, DATA -> STOP directly, parity_err tied 0; frame = 10 bits.

Verification
REQ-027 8N1 byte 8'hA5 at 16 ticks/bit (10400 sysclk/bit) -> rx_data=8'hA5, rx_valid=1, all flags 0.
REQ-028 Low glitch of 3 ticks on idle line -> stays IDLE, busy falls after tick 8, no rx_valid.
REQ-029 Byte 8'h3C with stop bit 0 -> frame_err=1, rx_valid=0, no re-arm until line high one tick.
REQ-030 Bytes 8'h11 then 8'h22 without rx_ack -> rx_data=8'h11, overrun=1; rx_ack clears rx_valid and overrun.
REQ-031 Reset asserted at data bit 4 of 8'hFF, then clean 8'h5A -> only 8'h5A delivered.
REQ-032 (UART_RX_PARITY_EN) 8'h07 with parity bit 0 -> rx_data=8'h07, rx_valid=1, parity_err=1.
